// File: rtl/cgr_kmer_addr.sv
// ---------------------------------------------------------------------------
// cgr_kmer_addr
//
// Chaos-game-representation address generator for 2-bit nucleotide streams.
// Each accepted base shifts bit1 into the x window and bit0 into the y window.
// Both windows shift in from the MSB, so the newest base always lands in the
// MSB. Once K bases have been seen since the last restart, the block emits a
// 2K-bit k-mer address {x, y}. The consumer uses it to bump a CGR frequency
// counter RAM.
//
// Ports
//   CLK, RST     clock; asynchronous active-high reset
//   sym_valid    input symbol valid
//   sym_ready    block can take a symbol this cycle (combinational)
//   sym          nucleotide code: bit1 -> x window, bit0 -> y window
//   sym_n        ambiguous base; sym ignored, window restarts
//   sym_last     final symbol of the current sequence
//   cfg_overlap  1 = sliding k-mers, 0 = non-overlapping k-mers. Latched on
//                the first symbol of each sequence.
//   addr_valid   k-mer address valid
//   addr_ready   consumer accepts the address
//   addr         {x_window, y_window}
//   addr_last    addr is the last k-mer of its sequence
//   seq_done     one-cycle pulse after a sym_last symbol is accepted
//   kmer_count   k-mers emitted since reset (saturating)
//   ambig_count  N symbols accepted since reset (saturating)
//
// Handshake semantics (both sides)
//   A transfer happens on a rising CLK edge where valid && ready are both
//   high. Once raised, valid stays high and its payload stays stable until
//   that transfer completes. Ready may depend combinationally on the
//   downstream ready: sym_ready = !addr_valid || addr_ready. The single
//   output register can therefore be refilled in the same cycle it drains,
//   which gives one k-mer per clock at full throughput.
// ---------------------------------------------------------------------------
module cgr_kmer_addr #(
  parameter int K     = 3,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             sym_valid,
  output logic             sym_ready,
  input  logic [1:0]       sym,
  input  logic             sym_n,
  input  logic             sym_last,
  input  logic             cfg_overlap,
  output logic             addr_valid,
  input  logic             addr_ready,
  output logic [2*K-1:0]   addr,
  output logic             addr_last,
  output logic             seq_done,
  output logic [CNT_W-1:0] kmer_count,
  output logic [CNT_W-1:0] ambig_count
);

  localparam int FILL_W = $clog2(K + 1);

  // CGR centre: MSB set, remaining bits clear.
  localparam logic [K-1:0]      WIN_INIT  = {1'b1, {(K-1){1'b0}}};
  localparam logic [FILL_W-1:0] FILL_ZERO = '0;
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(K);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  // Window phase, derived from the fill counter.
  localparam logic [0:0] PH_FILL = 1'b0;  // fewer than K bases in the window
  localparam logic [0:0] PH_RUN  = 1'b1;  // window holds K valid bases

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [K-1:0]      x_q;
  logic [K-1:0]      y_q;
  logic [FILL_W-1:0] fill_q;
  logic              overlap_q;   // overlap mode latched for this sequence
  logic              seq_active_q;

  // -------------------------------------------------------------------------
  // Combinational decode
  // -------------------------------------------------------------------------
  logic              accept;
  logic              mode_overlap;
  logic [0:0]        phase;
  logic [K-1:0]      x_shift;
  logic [K-1:0]      y_shift;
  logic [FILL_W-1:0] fill_inc;
  logic              emit;

  assign sym_ready = !addr_valid || addr_ready;
  assign accept    = sym_valid && sym_ready;

  // The first symbol of a sequence uses the live cfg_overlap value, because
  // the latch only updates on that same edge.
  assign mode_overlap = seq_active_q ? overlap_q : cfg_overlap;

  assign phase   = (fill_q == FILL_FULL) ? PH_RUN : PH_FILL;
  assign x_shift = {sym[1], x_q[K-1:1]};
  assign y_shift = {sym[0], y_q[K-1:1]};

  // Fill saturates at K. In overlap mode it parks in PH_RUN, so every
  // further base completes a k-mer.
  assign fill_inc = (phase == PH_RUN) ? fill_q : fill_q + 1'b1;

  assign emit = accept && !sym_n && (fill_inc == FILL_FULL);

  // -------------------------------------------------------------------------
  // Next-state for window and fill
  // -------------------------------------------------------------------------
  logic [K-1:0]      x_d;
  logic [K-1:0]      y_d;
  logic [FILL_W-1:0] fill_d;

  always_comb begin
    x_d    = x_q;
    y_d    = y_q;
    fill_d = fill_q;
    if (accept) begin
      if (sym_n) begin
        x_d    = WIN_INIT;
        y_d    = WIN_INIT;
        fill_d = FILL_ZERO;
      end else begin
        x_d = x_shift;
        y_d = y_shift;
        // Non-overlapping mode needs K fresh bases after each emit. The old
        // bases stay in the window but are fully shifted out before the
        // next emit.
        fill_d = (emit && !mode_overlap) ? FILL_ZERO : fill_inc;
      end
      // End of sequence takes priority. The emit above, if any, has already
      // captured the shifted window.
      if (sym_last) begin
        x_d    = WIN_INIT;
        y_d    = WIN_INIT;
        fill_d = FILL_ZERO;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      x_q    <= WIN_INIT;
      y_q    <= WIN_INIT;
      fill_q <= FILL_ZERO;
    end else begin
      x_q    <= x_d;
      y_q    <= y_d;
      fill_q <= fill_d;
    end
  end

  // -------------------------------------------------------------------------
  // Sequence tracking: overlap mode is sampled once per sequence
  // -------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      overlap_q    <= 1'b1;
      seq_active_q <= 1'b0;
    end else if (accept) begin
      if (!seq_active_q) begin
        overlap_q <= cfg_overlap;
      end
      seq_active_q <= !sym_last;
    end
  end

  // -------------------------------------------------------------------------
  // Output register slot
  // -------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      addr_valid <= 1'b0;
      addr       <= '0;
      addr_last  <= 1'b0;
    end else if (emit) begin
      // An emit only happens on an accept, and an accept only happens when
      // the slot is empty or draining this cycle. Overwriting is always safe.
      addr_valid <= 1'b1;
      addr       <= {x_shift, y_shift};
      addr_last  <= sym_last;
    end else if (addr_ready) begin
      addr_valid <= 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      seq_done <= 1'b0;
    end else begin
      seq_done <= accept && sym_last;
    end
  end

  // -------------------------------------------------------------------------
  // Saturating statistics
  // -------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      kmer_count <= '0;
    end else if (emit && (kmer_count != CNT_MAX)) begin
      kmer_count <= kmer_count + 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ambig_count <= '0;
    end else if (accept && sym_n && (ambig_count != CNT_MAX)) begin
      ambig_count <= ambig_count + 1'b1;
    end
  end

endmodule

// File: doc/cgr_kmer_addr.md
Name: cgr_kmer_addr

Overview:
- Parametrised chaos-game-representation (CGR) address generator for 2-bit nucleotide streams.
- Maintains a K-deep x/y shift window and emits a 2K-bit k-mer address per completed window, for frequency-table RAM writes.
- Adds over the fixed-length generator:
  - valid/ready handshakes on both sides;
  - warm-up gating;
  - ambiguous-base (N) window restart;
  - overlapping vs non-overlapping k-mer modes;
  - sequence-end signalling;
  - saturating statistics.
- Sits between the symbol decoder and the CGR counter RAM.

Parameters:
K, 3, k-mer length; x and y windows are each K bits; K >= 2
CNT_W, 16, width of the statistics counters

Ports:
CLK  in  1  clock
RST  in  1  asynchronous active-high reset
sym_valid  in  1  input symbol valid
sym_ready  out  1  block can accept a symbol this cycle
sym  in  2  nucleotide code; bit1 feeds x, bit0 feeds y
sym_n  in  1  ambiguous base; sym ignored, window restarts
sym_last  in  1  final symbol of the current sequence
cfg_overlap  in  1  1 = sliding k-mers (every symbol), 0 = non-overlapping (every K symbols)
addr_valid  out  1  k-mer address valid
addr_ready  in  1  consumer accepts address
addr  out  2K  {x_window, y_window}
addr_last  out  1  addr is the last k-mer of the sequence
seq_done  out  1  one-cycle pulse after a sym_last is accepted
kmer_count  out  CNT_W  k-mers emitted since reset; saturates at all-ones
ambig_count  out  CNT_W  N symbols accepted since reset; saturates

Behaviour:
- Reset values (asynchronous, also mid-operation):
  - x = y = init window: MSB=1, other bits 0 (CGR centre).
  - fill=0; addr_valid=0; addr=0; addr_last=0; seq_done=0; both counters 0.
  - Latched overlap mode = 1; seq_active=0.
- sym_ready = !addr_valid || addr_ready. This is combinational; an output register slot frees in the cycle it is consumed.
- Accept: a symbol is accepted when sym_valid && sym_ready.
- Window update on accepting a non-N symbol:
  - x <= {sym[1], x[K-1:1]};
  - y <= {sym[0], y[K-1:1]}.
- Fill counter (0..K) states:
  - FILL when fill < K.
  - RUN when fill == K.
  - A non-N accept increments fill, saturating at K.
- Emit condition: a non-N accept whose updated fill equals K emits.
  - Overlap mode: every such accept emits.
  - Non-overlap mode: after an emit, fill is reset to 0, so the next emit needs K further symbols.
- Emit timing and contents:
  - addr_valid rises on the next edge.
  - addr = {x_next, y_next}.
  - addr_last = sym_last of that symbol.
  - kmer_count increments.
  - Latency is one cycle from the accepting edge.
- Backpressure: while addr_valid && !addr_ready, addr and addr_last hold stable and no symbol is accepted.
- On addr handshake with no new emit, addr_valid drops next cycle. A simultaneous handshake and new emit keeps addr_valid high with the new data, giving full throughput.
- N symbol accept (sym_n=1):
  - x/y return to init; fill <= 0; ambig_count increments; no emit.
  - sym is don't-care.
- sym_last accept (any sym_n):
  - After that symbol's processing, x/y return to init, fill <= 0, seq_active <= 0.
  - seq_done pulses one cycle later.
  - If the last symbol does not complete a k-mer, nothing is emitted; seq_done alone marks the end.
- cfg_overlap is latched on the first accepted symbol while seq_active=0, then seq_active <= 1. Changes mid-sequence are ignored.
- A sequence of a single sym_last symbol with K > 1: no emit, seq_done pulses.
- Counters saturate at 2^CNT_W-1 and do not wrap.

Test Plan:
- K=3, overlap=1; accept sym 11, 10, 01 back-to-back, addr_ready=1:
  - x=011, y=101; addr=6'h1D; addr_valid exactly one cycle after the third accept;
  - nothing emitted after the first two symbols.
- Same sequence then sym 00:
  - second addr=6'h0A on the next cycle;
  - kmer_count=2.
- overlap=0 (latched at first symbol); six symbols 11,10,01,00,00,00:
  - emits only after the 3rd and 6th accepts;
  - the 4th and 5th accepts produce no addr_valid.
- Backpressure: addr_ready=0 for 4 cycles after an emit:
  - sym_ready=0 and addr is held stable;
  - on release, the queued symbol is accepted in the same cycle as the addr handshake.
- N handling: 11, N, 10, 01, 00:
  - first emit after the 00 (window restarted at the N);
  - ambig_count=1.
- sym_last on the 2nd symbol of a K=3 sequence:
  - no emit; seq_done pulse one cycle later; window back to init.
- Assert RST mid-window (fill=2): all outputs return to their reset values immediately, and a fresh 3-symbol sequence reproduces 6'h1D.
